slr_credit_rx: RTL and testbench



---
 rtl/slr_credit_rx.sv | 117 +++++++++++
 tb/tb_slr_credit_rx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/slr_credit_rx.sv
// slr_credit_rx: receive buffer at the end of an SLR crossing; returns one credit per consumed word.
// Latency: one cycle from in_valid into an empty block to out_valid (bypass into the output register).
// Backpressure: none upstream (credits bound occupancy); out_ready stalls the head; excess words are dropped and flagged.
module slr_credit_rx #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       sreset,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic                       credit_ret,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
);

  // The output register holds one word, so the memory only needs DEPTH-1 entries.
  localparam int MEM = DEPTH - 1;
  localparam int AW  = $clog2(MEM);
  localparam int LW  = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [MEM];

  logic [AW-1:0]    wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic             wr_wrap_q, wr_wrap_d, rd_wrap_q, rd_wrap_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             credit_q, credit_d;
  logic             overflow_q, overflow_d;

  logic [LW-1:0]    mem_cnt;
  logic [LW-1:0]    level_w;
  logic             mem_empty, full, pop, push_ok, head_free, mem_pop, mem_push, bypass;

  // Address wraps at MEM-1; the wrap bit flips so equal addresses can mean empty or full.
  function automatic logic [AW:0] ptr_inc(input logic wrap, input logic [AW-1:0] addr);
    if (addr == AW'(MEM - 1)) return {~wrap, {AW{1'b0}}};
    else                      return {wrap, addr + AW'(1)};
  endfunction

  // Occupancy from the pointer difference, then push/pop/bypass decisions.
  always_comb begin
    if (wr_wrap_q == rd_wrap_q) mem_cnt = LW'(wr_addr_q) - LW'(rd_addr_q);
    else                        mem_cnt = LW'(MEM) + LW'(wr_addr_q) - LW'(rd_addr_q);
    mem_empty = (mem_cnt == '0);
    level_w   = mem_cnt + LW'(out_valid_q);
    full      = (level_w == LW'(DEPTH));
    pop       = out_valid_q & out_ready;
    push_ok   = in_valid & (~full | pop);
    head_free = ~out_valid_q | pop;
    // The memory head always wins the output register so ordering is preserved.
    mem_pop   = head_free & ~mem_empty;
    bypass    = push_ok & mem_empty & head_free;
    mem_push  = push_ok & ~bypass;
  end

  // Next-state for pointers, output register, credit pulse and sticky overflow.
  always_comb begin
    wr_addr_d   = wr_addr_q;
    wr_wrap_d   = wr_wrap_q;
    rd_addr_d   = rd_addr_q;
    rd_wrap_d   = rd_wrap_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    credit_d    = pop;
    overflow_d  = overflow_q | (in_valid & ~push_ok);
    if (mem_push) {wr_wrap_d, wr_addr_d} = ptr_inc(wr_wrap_q, wr_addr_q);
    if (mem_pop)  {rd_wrap_d, rd_addr_d} = ptr_inc(rd_wrap_q, rd_addr_q);
    if (mem_pop) begin
      out_valid_d = 1'b1;
      out_data_d  = mem[rd_addr_q];
    end else if (bypass) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset flushes contents without returning credit.
  always_ff @(posedge clk) begin
    if (sreset) begin
      wr_addr_q   <= '0;
      wr_wrap_q   <= 1'b0;
      rd_addr_q   <= '0;
      rd_wrap_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      credit_q    <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_addr_q   <= wr_addr_d;
      wr_wrap_q   <= wr_wrap_d;
      rd_addr_q   <= rd_addr_d;
      rd_wrap_q   <= rd_wrap_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      credit_q    <= credit_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage array has no reset; only words behind the pointers are ever read.
  always_ff @(posedge clk) begin
    if (mem_push && !sreset) mem[wr_addr_q] <= in_data;
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign credit_ret = credit_q;
  assign level      = level_w;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_slr_credit_rx.sv
// Bench for slr_credit_rx: queue-based reference model checked every cycle, plus directed literal checks.
// Inputs change on the falling edge; outputs are compared on the falling edge after each rising edge.
// Randomized phase mixes pushes, stalls, overflow attempts and occasional resets.
module tb_slr_credit_rx;
  localparam int WIDTH = 16;
  localparam int DEPTH = 32;
  localparam int LW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             sreset, in_valid, out_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid, credit_ret, overflow;
  logic [WIDTH-1:0] out_data;
  logic [LW-1:0]    level;

  int n_tests = 0;
  int n_fail  = 0;

  slr_credit_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .sreset(sreset), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .credit_ret(credit_ret), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of held words; the head is what the consumer sees.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_last = '0;
  logic             m_credit = 1'b0;
  logic             m_ovf = 1'b0;

  always @(posedge clk) begin
    if (sreset) begin
      mq.delete();
      m_last   = '0;
      m_credit = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      m_credit = (mq.size() > 0) && out_ready;
      if (m_credit) m_last = mq.pop_front();
      if (in_valid) begin
        if (mq.size() < DEPTH) mq.push_back(in_data);
        else m_ovf = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (n_tests >= 0) begin
      chk("m_out_valid", 32'(out_valid), 32'(mq.size() > 0));
      chk("m_out_data", 32'(out_data), 32'(mq.size() > 0 ? mq[0] : m_last));
      chk("m_level", 32'(level), 32'(mq.size()));
      chk("m_credit", 32'(credit_ret), 32'(m_credit));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  // Apply inputs for one rising edge; returns on the following falling edge.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic rst = 1'b0);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    sreset    = rst;
    @(negedge clk);
  endtask

  task automatic expect_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_data"}, 32'(out_data), 0);
    chk({tag, "_level"}, 32'(level), 0);
    chk({tag, "_credit"}, 32'(credit_ret), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
  endtask

  int credits;

  initial begin
    sreset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    step(1'b1, 16'hFFFF, 1'b1, 1'b1);   // in_valid during reset is ignored
    step(1'b0, '0, 1'b0);
    expect_zero("reset");

    // Single word through the bypass path.
    step(1'b1, 16'h00A5, 1'b0);
    chk("single_valid", 32'(out_valid), 1);
    chk("single_data", 32'(out_data), 32'h00A5);
    chk("single_level", 32'(level), 1);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    chk("single_pop_valid", 32'(out_valid), 0);
    chk("single_pop_credit", 32'(credit_ret), 1);
    chk("single_pop_level", 32'(level), 0);
    step(1'b0, '0, 1'b0);
    chk("single_credit_once", 32'(credit_ret), 0);

    // Fill to DEPTH, then push and pop together while full.
    for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(i), 1'b0);
    chk("fill_level", 32'(level), DEPTH);
    chk("fill_ovf", 32'(overflow), 0);
    chk("fill_head", 32'(out_data), 0);
    step(1'b1, 16'h1234, 1'b1);
    chk("fullpp_level", 32'(level), DEPTH);
    chk("fullpp_ovf", 32'(overflow), 0);
    chk("fullpp_head", 32'(out_data), 1);

    // Overflow: push while full with no pop.
    step(1'b1, 16'hDEAD, 1'b0);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_level", 32'(level), DEPTH);

    // Drain: words 1..31 then 0x1234, one per cycle.
    credits = 0;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_word", 32'(out_data), (i == DEPTH - 1) ? 32'h1234 : 32'(i + 1));
      step(1'b0, '0, 1'b1);
      credits += int'(credit_ret);
    end
    step(1'b0, '0, 1'b1);
    credits += int'(credit_ret);
    chk("drain_credits", 32'(credits), DEPTH);
    chk("drain_level", 32'(level), 0);
    chk("ovf_sticky", 32'(overflow), 1);

    // Streaming: output follows input one cycle later.
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      step(1'b1, WIDTH'(16'h0100 + i), 1'b1);
      chk("stream_data", 32'(out_data), 32'h0100 + 32'(i));
      chk("stream_level", 32'(level), 1);
    end
    step(1'b0, '0, 1'b1);

    // Reset mid-operation at level 10.
    for (int i = 0; i < 10; i++) step(1'b1, WIDTH'(16'h0200 + i), 1'b0);
    chk("mid_level", 32'(level), 10);
    step(1'b0, '0, 1'b1, 1'b1);
    expect_zero("midrst");
    step(1'b1, 16'h00A5, 1'b0);
    chk("post_rst_data", 32'(out_data), 32'h00A5);
    chk("post_rst_level", 32'(level), 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 60), WIDTH'($urandom),
           ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 70 : 40)),
           ($urandom_range(0, 999) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
